note_scheduler: RTL
===================

// Module: note_scheduler
// PURPOSE
//  Arbitrates seven note-request inputs (board switches/keys) for the single tone generator.
//  - Synchronises and debounces each request.
//  - Selects one note under a newest-press-wins policy, with a minimum play time and a silent gap between notes.
//  - Emits the 3-bit note code (0 = silence, 1..7 = note) consumed by the note-to-one-hot decoder.
// PARAMETERS
//  DEBOUNCE_CYCLES  20'd500000  consecutive stable cycles before a synced request changes its debounced level (>=1)
//  MIN_HOLD         24'd2500000 minimum cycles a started note is held before it may change (>=1)
//  GAP_CYCLES       16'd25000   silent cycles between two different notes (0 = no gap)
//  ARP_PERIOD       24'd6250000 arpeggio step length in cycles; used only with NOTE_SCHED_ARP_EN
// PORTS
//  clk          in   1  system clock
//  resetn       in   1  synchronous, active-low reset
//  note_req     in   7  raw request levels; bit i = note i+1, asynchronous to clk
//  note_code    out  3  registered selected note; 0 = silence
//  note_valid   out  1  registered; 1 while note_code != 0
//  note_change  out  1  one-cycle pulse on the cycle note_code takes a new value
// BEHAVIOUR
//  Reset: one clock; reset is synchronous and active-low (resetn sampled on rising clk).
//  - At the first edge with resetn=0, clear all sync flops, debounce counters, debounced levels and counters.
//  - At that edge: state=IDLE, note_code=0, note_valid=0, note_change=0.
//  - Reset mid-note aborts it with no pulse.
//  Input path, per bit: 2-flop synchroniser, then debounce counter.
//  - Counter resets whenever the synced value equals the debounced level.
//  - The debounced level flips when the synced value has differed for DEBOUNCE_CYCLES cycles.
//  - Latency: req stable from edge k -> debounced flips at edge k+2+DEBOUNCE_CYCLES.
//  - A press event is a rising edge of a debounced bit.
//  - Several press events in one cycle: the lowest index wins.
//  FSM:
//  - IDLE: outputs silent.
//    - On any press event, go to PLAY with the winning note.
//    - note_code updates one edge after the debounced flip.
//    - Load hold_cnt=MIN_HOLD-1.
//  - PLAY: note_code=cur.
//    - hold_cnt decrements to 0 and saturates.
//    - A press event on another note sets pending=that note; a later press overwrites it.
//    - When hold_cnt==0, evaluate in order:
//      1. pending still held -> next=pending.
//      2. cur released and any note held -> next=lowest held index.
//      3. cur released, none held -> IDLE, silent on the next edge.
//      4. otherwise stay.
//    - Release of cur before hold_cnt==0 is ignored until expiry.
//    - Release then re-press of cur during the hold does not re-trigger.
//    - If next != cur: go to GAP (or straight to PLAY if GAP_CYCLES==0). Clear pending.
//  - GAP: note_code=0 for exactly GAP_CYCLES cycles.
//    - At the end, re-evaluate: pending/next if still held, else lowest held, else IDLE.
//    - A press during GAP sets pending.
//  Outputs:
//  - note_change fires on IDLE->PLAY, PLAY->GAP, GAP->PLAY, PLAY->IDLE and PLAY->PLAY (gapless).
//  - It never fires while note_code is unchanged.
//  - Counters are sized $clog2(param+1); no wrap: hold_cnt and gap_cnt saturate at 0.
// CONFIGURATION
//  NOTE_SCHED_ARP_EN defined: while in PLAY with >=2 notes held, step cur every ARP_PERIOD cycles.
//  - Each step moves to the next higher held index, wrapping to the lowest.
//  - Steps are gapless; each step pulses note_change.
//  - Press events are ignored for selection while arpeggiating.
//  - With <=1 note held, behaviour is as in the undefined case.
//  NOTE_SCHED_ARP_EN undefined: no arpeggio logic or counter is built and ARP_PERIOD is unused; behaviour is exactly as above.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, MIN_HOLD=8, GAP_CYCLES=2, ARP_PERIOD=5)
//  1. Reset: resetn=0 for 1 cycle with note_req=7'h7F.
//     -> next edge: note_code=0, note_valid=0, note_change=0.
//  2. note_req[2] 0->1 at edge k.
//     -> note_code=3 and note_change=1 at edge k+7; note_valid=1 thereafter.
//  3. Bounce: note_req[0] toggles every 2 cycles for 20 cycles, then returns to 0.
//     -> note_code stays 0, no note_change.
//  4. Hold note 3, press note 6 one cycle after note 3 starts; hold both.
//     -> note 3 for 8 cycles, then 0 for 2 cycles, then 6; three note_change pulses.
//  5. Simultaneous press of notes 2 and 5 from IDLE.
//     -> note_code=2. Release 2 after 3 cycles -> 2 kept until hold expiry, 2-cycle gap, then 5.
//  6. ARP_EN: hold notes 1, 4, 7.
//     -> sequence 1 (held 8), then 4, 7, 1 ... changing every 5 cycles with no zero gaps.
//     -> Release all: IDLE, note_code=0.

Source files
------------

// File: rtl/note_scheduler.sv
// Seven-input note arbiter: synchronise + debounce each request, newest-press-wins selection
// with minimum hold and silent gap. Optional arpeggiator enabled by defining NOTE_SCHED_ARP_EN.
module note_scheduler #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [23:0] MIN_HOLD        = 24'd2500000,
    parameter logic [15:0] GAP_CYCLES      = 16'd25000,
    parameter logic [23:0] ARP_PERIOD      = 24'd6250000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] note_req,
    output logic [2:0] note_code,
    output logic       note_valid,
    output logic       note_change
);

    localparam int DW = $clog2(int'(DEBOUNCE_CYCLES) + 1);
    localparam int HW = $clog2(int'(MIN_HOLD) + 1);
    localparam int GW = (GAP_CYCLES == 16'd0) ? 1 : $clog2(int'(GAP_CYCLES) + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 20'd1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD - 24'd1);
    localparam logic [GW-1:0] GAP_LOAD  = (GAP_CYCLES == 16'd0) ? GW'(0) : GW'(GAP_CYCLES - 16'd1);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

    logic [6:0]    sync1_r, sync2_r, deb_r, deb_d_r;
    logic [DW-1:0] db_cnt_r [7];
    logic [6:0]    press_s, press_other_s;
    state_t        state_r, state_nx;
    logic [2:0]    cur_r, cur_nx, pend_r, pend_nx, tgt_r, tgt_nx, sel_s, code_nx;
    logic [HW-1:0] hold_r, hold_nx;
    logic [GW-1:0] gap_r, gap_nx;
    logic          chg_nx;
    logic          arp_active_s;

    // Lowest set index as a note code (0 when empty)
    function automatic logic [2:0] lowest(input logic [6:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (v[i]) r = 3'(i + 1);
        end
        return r;
    endfunction

    function automatic logic is_held(input logic [6:0] v, input logic [2:0] code);
        if (code == 3'd0) return 1'b0;
        else return v[code - 3'd1];
    endfunction

    function automatic logic [6:0] note_mask(input logic [2:0] code);
        case (code)
            3'd1:    return 7'b0000001;
            3'd2:    return 7'b0000010;
            3'd3:    return 7'b0000100;
            3'd4:    return 7'b0001000;
            3'd5:    return 7'b0010000;
            3'd6:    return 7'b0100000;
            3'd7:    return 7'b1000000;
            default: return 7'b0000000;
        endcase
    endfunction

`ifdef NOTE_SCHED_ARP_EN
    localparam int AW = $clog2(int'(ARP_PERIOD) + 1);
    localparam logic [AW-1:0] ARP_LOAD = AW'(ARP_PERIOD - 24'd1);
    logic [AW-1:0] arp_r, arp_nx;

    // Next higher held note above code, wrapping round to the lowest
    function automatic logic [2:0] next_higher(input logic [6:0] v, input logic [2:0] code);
        logic [2:0] r;
        int idx;
        r = code;
        for (int k = 6; k >= 1; k--) begin
            idx = (int'(code) - 1 + k) % 7;
            if (v[idx]) r = 3'(idx + 1);
        end
        return r;
    endfunction

    assign arp_active_s = (state_r == PLAY) && ($countones(deb_r) >= 2);
`else
    assign arp_active_s = 1'b0;
`endif

    assign press_s       = deb_r & ~deb_d_r;
    assign press_other_s = press_s & ~note_mask(cur_r);

    // Synchroniser and per-bit debounce counters
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_r <= 7'd0;
            sync2_r <= 7'd0;
            deb_r   <= 7'd0;
            deb_d_r <= 7'd0;
            for (int i = 0; i < 7; i++) db_cnt_r[i] <= '0;
        end else begin
            sync1_r <= note_req;
            sync2_r <= sync1_r;
            deb_d_r <= deb_r;
            for (int i = 0; i < 7; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    db_cnt_r[i] <= '0;
                    deb_r[i]    <= sync2_r[i];
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
                end
            end
        end
    end

    // Next-state and next-output selection
    always_comb begin
        state_nx = state_r;
        cur_nx   = cur_r;
        pend_nx  = pend_r;
        tgt_nx   = tgt_r;
        hold_nx  = hold_r;
        gap_nx   = gap_r;
        code_nx  = note_code;
        chg_nx   = 1'b0;
        sel_s    = 3'd0;
`ifdef NOTE_SCHED_ARP_EN
        arp_nx   = '0;
`endif
        case (state_r)
            IDLE: begin
                if (|press_s) begin
                    state_nx = PLAY;
                    cur_nx   = lowest(press_s);
                    code_nx  = lowest(press_s);
                    hold_nx  = HOLD_LOAD;
                    pend_nx  = 3'd0;
                    chg_nx   = 1'b1;
                end else begin
                    code_nx  = 3'd0;
                end
            end
            PLAY: begin
                if (hold_r != '0) hold_nx = hold_r - HW'(1);
                else hold_nx = hold_r;
                if (arp_active_s) begin
                    pend_nx = 3'd0;
`ifdef NOTE_SCHED_ARP_EN
                    if (hold_r == '0 && arp_r == '0) begin
                        cur_nx  = next_higher(deb_r, cur_r);
                        code_nx = next_higher(deb_r, cur_r);
                        chg_nx  = 1'b1;
                        arp_nx  = ARP_LOAD;
                    end else if (arp_r != '0) begin
                        arp_nx  = arp_r - AW'(1);
                    end else begin
                        arp_nx  = arp_r;
                    end
`endif
                end else begin
                    if (|press_other_s) pend_nx = lowest(press_other_s);
                    else pend_nx = pend_r;
                    if (hold_r == '0) begin
                        // Pending press beats fallback to the lowest held note
                        if (pend_r != 3'd0 && is_held(deb_r, pend_r)) sel_s = pend_r;
                        else if (!is_held(deb_r, cur_r)) sel_s = lowest(deb_r);
                        else sel_s = 3'd0;
                        if (sel_s != 3'd0) begin
                            pend_nx = 3'd0;
                            chg_nx  = 1'b1;
                            if (GAP_CYCLES == 16'd0) begin
                                cur_nx  = sel_s;
                                code_nx = sel_s;
                                hold_nx = HOLD_LOAD;
                            end else begin
                                state_nx = GAP;
                                tgt_nx   = sel_s;
                                gap_nx   = GAP_LOAD;
                                code_nx  = 3'd0;
                            end
                        end else if (!is_held(deb_r, cur_r)) begin
                            state_nx = IDLE;
                            cur_nx   = 3'd0;
                            pend_nx  = 3'd0;
                            code_nx  = 3'd0;
                            chg_nx   = 1'b1;
                        end else begin
                            code_nx  = cur_r;
                        end
                    end else begin
                        code_nx = cur_r;
                    end
                end
            end
            GAP: begin
                if (|press_s) pend_nx = lowest(press_s);
                else pend_nx = pend_r;
                if (gap_r != '0) begin
                    gap_nx = gap_r - GW'(1);
                end else begin
                    if (pend_r != 3'd0 && is_held(deb_r, pend_r)) sel_s = pend_r;
                    else if (is_held(deb_r, tgt_r)) sel_s = tgt_r;
                    else sel_s = lowest(deb_r);
                    pend_nx = 3'd0;
                    if (sel_s != 3'd0) begin
                        state_nx = PLAY;
                        cur_nx   = sel_s;
                        code_nx  = sel_s;
                        hold_nx  = HOLD_LOAD;
                        chg_nx   = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        cur_nx   = 3'd0;
                        code_nx  = 3'd0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cur_nx   = 3'd0;
                code_nx  = 3'd0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= IDLE;
            cur_r       <= 3'd0;
            pend_r      <= 3'd0;
            tgt_r       <= 3'd0;
            hold_r      <= '0;
            gap_r       <= '0;
            note_code   <= 3'd0;
            note_valid  <= 1'b0;
            note_change <= 1'b0;
`ifdef NOTE_SCHED_ARP_EN
            arp_r       <= '0;
`endif
        end else begin
            state_r     <= state_nx;
            cur_r       <= cur_nx;
            pend_r      <= pend_nx;
            tgt_r       <= tgt_nx;
            hold_r      <= hold_nx;
            gap_r       <= gap_nx;
            note_code   <= code_nx;
            note_valid  <= (code_nx != 3'd0);
            note_change <= chg_nx;
`ifdef NOTE_SCHED_ARP_EN
            arp_r       <= arp_nx;
`endif
        end
    end

endmodule
